// File: rtl/pat_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package pat_loader_pkg;

    localparam int D_W         = 8;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 40;
    localparam int FRAME_BYTES = 7;
    localparam int PAD_W       = FRAME_BYTES * D_W - ADDR_W - DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

endpackage

// File: rtl/imem_load_ctrl_rise_detect.sv
// Rising-edge detector for an already-synchronised level: one flop plus an AND.
module rise_detect (
    input  logic clk_int,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Assembles fixed-length byte frames from port A into iMem address/data writes
// while holding the core in reset during memory-load mode.
module imem_load_ctrl #(
    parameter int D_W         = pat_loader_pkg::D_W,
    parameter int ADDR_W      = pat_loader_pkg::ADDR_W,
    parameter int DATA_W      = pat_loader_pkg::DATA_W,
    parameter int FRAME_BYTES = pat_loader_pkg::FRAME_BYTES
) (
    input  logic              clk_int,
    input  logic              reset,
    input  logic              load_mode,
    input  logic [D_W-1:0]    byte_in,
    input  logic              byte_strobe,
    input  logic              frame_sync,
    output logic [ADDR_W-1:0] imem_write_adr,
    output logic [DATA_W-1:0] imem_in,
    output logic              imem_write,
    output logic              core_hold,
    output logic [ADDR_W:0]   words_loaded,
    output logic              frame_error,
    output logic              busy
);

    import pat_loader_pkg::*;

    localparam int FRAME_W = FRAME_BYTES * D_W;
    localparam int SHIFT_W = (FRAME_BYTES - 1) * D_W;
    localparam int CNT_W   = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    generate
        if (FRAME_BYTES != (ADDR_W + DATA_W + D_W - 1) / D_W) begin : g_bad_frame_bytes
            $error("FRAME_BYTES must equal ceil((ADDR_W+DATA_W)/D_W)");
        end
    endgenerate

    logic strobe_rise;
    logic sync_rise;

    rise_detect u_strobe_rise (
        .clk_int (clk_int),
        .reset   (reset),
        .level   (byte_strobe),
        .rise    (strobe_rise)
    );

    rise_detect u_sync_rise (
        .clk_int (clk_int),
        .reset   (reset),
        .level   (frame_sync),
        .rise    (sync_rise)
    );

    state_t              state_reg,  state_next;
    logic [CNT_W-1:0]    count_reg,  count_next;
    logic [CNT_W-1:0]    count_base;
    logic [SHIFT_W-1:0]  shift_reg,  shift_next;
    logic [ADDR_W-1:0]   adr_reg,    adr_next;
    logic [DATA_W-1:0]   data_reg,   data_next;
    logic                write_reg,  write_next;
    logic [ADDR_W:0]     words_reg,  words_next;
    logic                error_reg,  error_next;
    logic [FRAME_W-1:0]  frame_word;
    logic                pad_bad;

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            shift_reg <= '0;
            adr_reg   <= '0;
            data_reg  <= '0;
            write_reg <= 1'b0;
            words_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            shift_reg <= shift_next;
            adr_reg   <= adr_next;
            data_reg  <= data_next;
            write_reg <= write_next;
            words_reg <= words_next;
            error_reg <= error_next;
        end
    end

    // Big-endian frame: earliest byte lands in the top bits, pad above the address.
    assign frame_word = {shift_reg, byte_in};
    assign pad_bad    = |(frame_word >> (ADDR_W + DATA_W));

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        count_base = count_reg;
        shift_next = shift_reg;
        adr_next   = adr_reg;
        data_next  = data_reg;
        write_next = 1'b0;
        words_next = words_reg;
        error_next = error_reg;

        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (load_mode) begin
                    state_next = COLLECT;
                    words_next = '0;
                    error_next = 1'b0;
                end
            end

            COLLECT, WRITE: begin
                if (state_reg == WRITE && words_reg != '1) begin
                    words_next = words_reg + 1'b1;
                end

                if (!load_mode) begin
                    state_next = IDLE;
                    count_next = '0;
                    if (count_reg != '0) begin
                        error_next = 1'b1;
                    end
                end else begin
                    state_next = COLLECT;
                    // Sync is applied before a coincident strobe so that byte becomes byte 0.
                    if (sync_rise) begin
                        count_base = '0;
                        if (count_reg != '0) begin
                            error_next = 1'b1;
                        end
                    end
                    count_next = count_base;
                    if (strobe_rise) begin
                        shift_next = {shift_reg[SHIFT_W-D_W-1:0], byte_in};
                        if (count_base == LAST_BYTE) begin
                            count_next = '0;
                            if (pad_bad) begin
                                error_next = 1'b1;
                            end else begin
                                adr_next   = frame_word[ADDR_W+DATA_W-1:DATA_W];
                                data_next  = frame_word[DATA_W-1:0];
                                write_next = 1'b1;
                                state_next = WRITE;
                            end
                        end else begin
                            count_next = count_base + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign imem_write_adr = adr_reg;
    assign imem_in        = data_reg;
    assign imem_write     = write_reg;
    assign words_loaded   = words_reg;
    assign frame_error    = error_reg;
    assign core_hold      = load_mode | (state_reg != IDLE);
    assign busy           = (count_reg != '0) | (state_reg == WRITE);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: frames, framing errors, mode drop and reset.
module tb_imem_load_ctrl;

    logic        clk_int     = 1'b0;
    logic        reset       = 1'b1;
    logic        load_mode   = 1'b0;
    logic [7:0]  byte_in     = 8'h00;
    logic        byte_strobe = 1'b0;
    logic        frame_sync  = 1'b0;
    logic [9:0]  imem_write_adr;
    logic [39:0] imem_in;
    logic        imem_write;
    logic        core_hold;
    logic [10:0] words_loaded;
    logic        frame_error;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    imem_load_ctrl dut (
        .clk_int        (clk_int),
        .reset          (reset),
        .load_mode      (load_mode),
        .byte_in        (byte_in),
        .byte_strobe    (byte_strobe),
        .frame_sync     (frame_sync),
        .imem_write_adr (imem_write_adr),
        .imem_in        (imem_in),
        .imem_write     (imem_write),
        .core_hold      (core_hold),
        .words_loaded   (words_loaded),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    always #5 clk_int = ~clk_int;

    always @(negedge clk_int) begin
        if (imem_write) wr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in     = b;
        byte_strobe = 1'b1;
        @(negedge clk_int);
        byte_strobe = 1'b0;
        @(negedge clk_int);
    endtask

    task automatic sync_pulse();
        frame_sync = 1'b1;
        @(negedge clk_int);
        frame_sync = 1'b0;
        @(negedge clk_int);
    endtask

    task automatic relaunch();
        load_mode = 1'b0;
        repeat (2) @(negedge clk_int);
        load_mode = 1'b1;
        @(negedge clk_int);
    endtask

    task automatic send_frame(input logic [55:0] w, input bit exp_wr,
                              input logic [9:0] exp_adr, input logic [39:0] exp_data,
                              input string tag);
        for (int i = 0; i < 6; i++) begin
            send_byte(w[55-8*i -: 8]);
        end
        byte_in     = w[7:0];
        byte_strobe = 1'b1;
        @(negedge clk_int);
        byte_strobe = 1'b0;
        check({tag, "_wr"}, imem_write, exp_wr);
        if (exp_wr) begin
            check({tag, "_adr"}, imem_write_adr, exp_adr);
            check({tag, "_data"}, imem_in, exp_data);
        end
        @(negedge clk_int);
        check({tag, "_wr_end"}, imem_write, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk_int);
        check("rst_adr", imem_write_adr, 0);
        check("rst_data", imem_in, 0);
        check("rst_wr", imem_write, 0);
        check("rst_hold", core_hold, 0);
        check("rst_words", words_loaded, 0);
        check("rst_err", frame_error, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk_int);
        check("idle_hold", core_hold, 0);

        load_mode = 1'b1;
        @(negedge clk_int);
        check("load_hold", core_hold, 1);
        check("load_busy", busy, 0);
        sync_pulse();
        check("first_sync_err", frame_error, 0);

        send_frame(56'h00_02_AB_11_22_33_44, 1'b1, 10'h002, 40'hAB11223344, "t1");
        check("t1_words", words_loaded, 1);
        check("t1_wrcnt", wr_cnt, 1);
        check("t1_busy", busy, 0);

        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("part_busy", busy, 1);
        check("part_err", frame_error, 0);
        sync_pulse();
        check("sync_err", frame_error, 1);
        check("sync_busy", busy, 0);
        check("sync_wrcnt", wr_cnt, 1);
        check("sync_adr_held", imem_write_adr, 10'h002);
        send_frame(56'h01_3F_DE_AD_BE_EF_01, 1'b1, 10'h13F, 40'hDEADBEEF01, "t2");
        check("t2_words", words_loaded, 2);

        send_frame(56'h00_10_00_00_00_00_01, 1'b1, 10'h010, 40'h0000000001, "b2b0");
        send_frame(56'h03_FF_FF_FF_FF_FF_FF, 1'b1, 10'h3FF, 40'hFFFFFFFFFF, "b2b1");
        check("b2b_words", words_loaded, 4);
        check("b2b_wrcnt", wr_cnt, 4);

        relaunch();
        check("relaunch_err", frame_error, 0);
        check("relaunch_words", words_loaded, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        frame_sync = 1'b1;
        send_frame(56'h02_20_12_34_56_78_9A, 1'b1, 10'h220, 40'h123456789A, "coinc");
        frame_sync = 1'b0;
        check("coinc_err", frame_error, 1);
        check("coinc_words", words_loaded, 1);

        relaunch();
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        load_mode = 1'b0;
        #1;
        check("drop_hold_before", core_hold, 1);
        @(negedge clk_int);
        check("drop_hold_after", core_hold, 0);
        check("drop_err", frame_error, 1);
        check("drop_busy", busy, 0);
        load_mode = 1'b1;
        @(negedge clk_int);
        check("reload_err", frame_error, 0);
        check("reload_words", words_loaded, 0);
        check("reload_hold", core_hold, 1);

        send_frame(56'h04_55_66_77_88_99_AA, 1'b0, 10'h000, 40'h0, "pad");
        check("pad_err", frame_error, 1);
        check("pad_adr_held", imem_write_adr, 10'h220);
        check("pad_data_held", imem_in, 40'h123456789A);
        check("pad_words", words_loaded, 0);
        check("pad_wrcnt", wr_cnt, 5);
        send_frame(56'h00_01_00_00_00_00_02, 1'b1, 10'h001, 40'h0000000002, "after_pad");
        check("after_pad_words", words_loaded, 1);

        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hBA);
        send_byte(8'hBE);
        byte_in     = 8'h00;
        byte_strobe = 1'b1;
        @(negedge clk_int);
        check("rstw_wr", imem_write, 1);
        #1;
        reset       = 1'b1;
        load_mode   = 1'b0;
        byte_strobe = 1'b0;
        #1;
        check("rstw_wr_drop", imem_write, 0);
        check("rstw_adr", imem_write_adr, 0);
        check("rstw_data", imem_in, 0);
        check("rstw_words", words_loaded, 0);
        check("rstw_err", frame_error, 0);
        check("rstw_hold", core_hold, 0);
        check("rstw_busy", busy, 0);
        @(negedge clk_int);
        reset = 1'b0;
        repeat (3) @(negedge clk_int);
        check("rstw_wrcnt", wr_cnt, 7);
        check("rstw_wr_idle", imem_write, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
